// File: rtl/dca_matrix_lsu_load.sv
// Load-side data mover: one LPIXM read request per transaction, read beats
// buffered in a small FIFO and streamed out with the burst's final beat tagged.
module dca_matrix_lsu_load #(
  parameter int BW_DATA       = 32,
  parameter int BW_ADDR       = 32,
  parameter int BW_ALEN       = 8,
  parameter int BW_LPI_BURDEN = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [BW_LPI_BURDEN-1:0] burden,
  input  logic                     txn_valid,
  input  logic [BW_ADDR+2:0]       txn_bitaddr,
  input  logic [BW_ALEN-1:0]       txn_alen,
  input  logic                     txn_last,
  output logic                     txn_ready,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [BW_ADDR-1:0]       req_addr,
  output logic [BW_ALEN-1:0]       req_alen,
  output logic [BW_LPI_BURDEN-1:0] req_burden,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [BW_DATA-1:0]       rsp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BW_DATA-1:0]       out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
  localparam int BW_OFS = $clog2(BW_DATA/8);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [BW_ADDR-1:0] ADDR_MASK = ~BW_ADDR'((64'd1 << BW_OFS) - 64'd1);

  typedef enum logic [2:0] {IDLE, REQ, DATA, FLUSH, DISCARD} state_t;

  state_t                   state_q, state_d;
  logic [BW_ALEN-1:0]       cnt_q, cnt_d, alen_q, alen_d;
  logic [BW_ADDR-1:0]       addr_q, addr_d;
  logic [BW_LPI_BURDEN-1:0] burden_q, burden_d;
  logic                     abort_q, abort_d;
  logic                     req_valid_q;

  logic [BW_DATA:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      fcnt_q;
  logic             empty, full, push, pop, beat;

  assign empty = (fcnt_q == '0);
  assign full  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = ~empty & out_ready;
  assign beat  = rsp_valid & rsp_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alen_d    = alen_q;
    addr_d    = addr_q;
    burden_d  = burden_q;
    abort_d   = abort_q;
    rsp_ready = 1'b0;
    txn_ready = 1'b0;
    done      = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: if (!clear && enable && txn_valid) begin
        if (txn_last) state_d = FLUSH;
        else begin
          addr_d   = txn_bitaddr[BW_ADDR+2:3] & ADDR_MASK;
          alen_d   = txn_alen;
          burden_d = burden;
          state_d  = REQ;
        end
      end
      REQ: begin
        // A request already on the bus is never retracted; an abort is
        // remembered and takes effect once the handshake completes.
        if (clear) abort_d = 1'b1;
        if (req_ready) begin
          cnt_d   = alen_q;
          abort_d = 1'b0;
          state_d = (clear || abort_q) ? DISCARD : DATA;
        end
      end
      DATA: begin
        rsp_ready = ~full;
        if (beat) begin
          cnt_d = cnt_q - BW_ALEN'(1);
          push  = ~clear;
          if (cnt_q == '0) begin
            txn_ready = ~clear;
            state_d   = IDLE;
          end
        end
        if (clear && !(beat && cnt_q == '0)) state_d = DISCARD;
      end
      FLUSH: begin
        if (clear) state_d = IDLE;
        else if (empty) begin
          txn_ready = 1'b1;
          done      = 1'b1;
          state_d   = IDLE;
        end
      end
      DISCARD: begin
        rsp_ready = 1'b1;
        if (rsp_valid) begin
          if (cnt_q == '0) state_d = IDLE;
          else cnt_d = cnt_q - BW_ALEN'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alen_q      <= '0;
      addr_q      <= '0;
      burden_q    <= '0;
      abort_q     <= 1'b0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alen_q      <= alen_d;
      addr_q      <= addr_d;
      burden_q    <= burden_d;
      abort_q     <= abort_d;
      req_valid_q <= (state_d == REQ);
    end
  end

  // Fullness is sampled before the pop, so a full FIFO never accepts a beat
  // even when the head drains in the same cycle.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else if (clear) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {(cnt_q == '0), rsp_data};
  end

  assign out_valid  = ~empty;
  assign out_data   = out_valid ? mem_q[rp_q][BW_DATA-1:0] : '0;
  assign out_last   = out_valid & mem_q[rp_q][BW_DATA];
  assign req_valid  = req_valid_q;
  assign req_addr   = addr_q;
  assign req_alen   = alen_q;
  assign req_burden = burden_q;
  assign busy       = (state_q != IDLE) | ~empty;
endmodule

// File: tb/tb_dca_matrix_lsu_load.sv
// Directed bench for dca_matrix_lsu_load: table of single transactions plus
// hand-written sequences for backpressure, flush, clear and reset corners.
module tb_dca_matrix_lsu_load;
  logic        clk = 1'b0;
  logic        rstnn, clear, enable;
  logic [0:0]  burden;
  logic        txn_valid, txn_last, txn_ready;
  logic [34:0] txn_bitaddr;
  logic [7:0]  txn_alen, req_alen;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [0:0]  req_burden;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data, out_data;
  logic        out_valid, out_ready, out_last, busy, done;

  always #5 clk = ~clk;

  dca_matrix_lsu_load dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .burden(burden),
    .txn_valid(txn_valid), .txn_bitaddr(txn_bitaddr), .txn_alen(txn_alen),
    .txn_last(txn_last), .txn_ready(txn_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_alen(req_alen), .req_burden(req_burden),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [34:0] bitaddr;
    logic [7:0]  alen;
    logic [0:0]  bur;
    logic [31:0] d0;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        vtab [4];
  logic [32:0] got [$];
  int          tr_cnt = 0, dn_cnt = 0, ov_cnt = 0;
  int          checks = 0, errors = 0;

  // Stream/pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstnn) begin
      if (out_valid && out_ready) got.push_back({out_last, out_data});
      if (txn_ready) tr_cnt++;
      if (done)      dn_cnt++;
      if (out_valid) ov_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic [31:0] base, input int n, output logic ok, output logic tr_last);
    int k = 0;
    int budget = n * 4 + 8;
    logic acc;
    tr_last = 1'b0;
    while (k < n && budget > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = base + k;
      #1;
      acc = rsp_ready;
      if (acc) tr_last = txn_ready;
      step();
      if (acc) k++;
      budget--;
    end
    rsp_valid = 1'b0;
    ok = (k == n);
  endtask

  task automatic beat_chk(input string nm, input int idx, input logic [31:0] d, input logic l);
    if (idx < got.size()) chk(nm, got[idx], {l, d});
    else chk({nm, "_missing"}, 64'd0, 64'd1);
  endtask

  task automatic start_txn(input logic [34:0] ba, input logic [7:0] al, input logic lst);
    enable = 1'b1; txn_valid = 1'b1; txn_bitaddr = ba; txn_alen = al; txn_last = lst;
  endtask

  task automatic run_vec(input vec_t v);
    int g0 = got.size();
    int t0 = tr_cnt;
    logic ok, trl;
    burden = v.bur; req_ready = 1'b1; out_ready = 1'b1;
    start_txn(v.bitaddr, v.alen, 1'b0);
    #1 chk("idle_txn_ready", txn_ready, 0);
    step();
    chk("req_valid", req_valid, 1);
    chk("req_addr", req_addr, v.exp_addr);
    chk("req_alen", req_alen, v.alen);
    chk("req_burden", req_burden, v.bur);
    step();
    chk("req_valid_drop", req_valid, 0);
    feed(v.d0, int'(v.alen) + 1, ok, trl);
    txn_valid = 1'b0;
    chk("feed_ok", ok, 1);
    chk("txn_ready_last_beat", trl, 1);
    step(); step();
    chk("beat_count", got.size() - g0, int'(v.alen) + 1);
    for (int i = 0; i <= int'(v.alen); i++)
      beat_chk("vec_beat", g0 + i, v.d0 + i, i == int'(v.alen));
    chk("txn_ready_pulses", tr_cnt - t0, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    logic ok, trl;
    int g0, t0, o0, d0, budget, seen;

    vtab[0] = '{35'h10013,     8'd0, 1'b0, 32'hA5A5A5A5, 32'h00002000};
    vtab[1] = '{35'h7FF,       8'd3, 1'b1, 32'h11110000, 32'h000000FC};
    vtab[2] = '{35'h20,        8'd1, 1'b0, 32'hDEAD0000, 32'h00000004};
    vtab[3] = '{35'h7FFFFFFFF, 8'd2, 1'b1, 32'h80000000, 32'hFFFFFFFC};

    rstnn = 1'b0; clear = 1'b0; enable = 1'b0; burden = '0;
    txn_valid = 1'b0; txn_bitaddr = '0; txn_alen = '0; txn_last = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_alen", req_alen, 0);
    chk("rst_req_burden", req_burden, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_txn_ready", txn_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_last, out_data}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    rstnn = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_vec(vtab[i]);

    // alen 3 with the consumer stalled: FIFO fills exactly, then drains in order.
    g0 = got.size();
    out_ready = 1'b0; req_ready = 1'b1;
    start_txn(35'h100, 8'd3, 1'b0);
    step(); step();
    feed(32'h100, 4, ok, trl);
    txn_valid = 1'b0;
    chk("a_feed_ok", ok, 1);
    chk("a_txn_ready", trl, 1);
    chk("a_out_valid", out_valid, 1);
    chk("a_busy", busy, 1);
    chk("a_head_last", out_last, 0);
    out_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++) beat_chk("a_beat", g0 + i, 32'h100 + i, i == 3);
    chk("a_count", got.size() - g0, 4);

    // alen 5 with the consumer stalled: rsp_ready drops after 4 beats.
    g0 = got.size();
    out_ready = 1'b0;
    start_txn(35'h200, 8'd5, 1'b0);
    step(); step();
    feed(32'h200, 4, ok, trl);
    chk("b_feed4_ok", ok, 1);
    chk("b_no_early_txn_ready", trl, 0);
    rsp_valid = 1'b1; rsp_data = 32'h204;
    #1 chk("b_full_rsp_ready", rsp_ready, 0);
    step();
    chk("b_full_rsp_ready2", rsp_ready, 0);
    out_ready = 1'b1;
    #1 chk("b_full_before_pop", rsp_ready, 0);
    step();
    feed(32'h204, 2, ok, trl);
    txn_valid = 1'b0;
    chk("b_feed2_ok", ok, 1);
    chk("b_txn_ready", trl, 1);
    repeat (6) step();
    chk("b_count", got.size() - g0, 6);
    for (int i = 0; i < 6; i++) beat_chk("b_beat", g0 + i, 32'h200 + i, i == 5);

    // txn_last waits for two buffered beats before done/txn_ready.
    g0 = got.size();
    out_ready = 1'b0;
    start_txn(35'h300, 8'd1, 1'b0);
    step(); step();
    feed(32'h300, 2, ok, trl);
    chk("c_feed_ok", ok, 1);
    start_txn(35'h0, 8'd0, 1'b1);
    d0 = dn_cnt; t0 = tr_cnt;
    step();
    for (int i = 0; i < 3; i++) begin
      #1 chk("c_hold_done", {done, txn_ready}, 0);
      step();
    end
    out_ready = 1'b1;
    seen = 0; budget = 10;
    while (seen == 0 && budget > 0) begin
      #1;
      if (done) begin
        seen = 1;
        chk("c_done_with_txn_ready", txn_ready, 1);
        chk("c_fifo_empty_at_done", out_valid, 0);
      end
      step();
      budget--;
    end
    txn_valid = 1'b0; txn_last = 1'b0;
    chk("c_done_seen", seen, 1);
    #1 chk("c_done_one_cycle", done, 0);
    step();
    chk("c_done_pulses", dn_cnt - d0, 1);
    chk("c_txn_ready_pulses", tr_cnt - t0, 1);
    chk("c_drained", got.size() - g0, 2);

    // clear mid-DATA after one of four beats.
    g0 = got.size(); t0 = tr_cnt;
    out_ready = 1'b0;
    start_txn(35'h400, 8'd3, 1'b0);
    step(); step();
    feed(32'h400, 1, ok, trl);
    txn_valid = 1'b0; clear = 1'b1;
    #1 chk("d_buffered", out_valid, 1);
    chk("d_clear_txn_ready", txn_ready, 0);
    step();
    clear = 1'b0;
    o0 = ov_cnt;
    chk("d_fifo_cleared", out_valid, 0);
    chk("d_busy", busy, 1);
    feed(32'h500, 3, ok, trl);
    chk("d_discard_ok", ok, 1);
    chk("d_idle", busy, 0);
    chk("d_no_out", ov_cnt - o0, 0);
    chk("d_no_txn_ready", tr_cnt - t0, 0);

    // clear in REQ with req_ready low for three cycles.
    g0 = got.size(); t0 = tr_cnt; o0 = ov_cnt;
    req_ready = 1'b0; out_ready = 1'b1;
    start_txn(35'h600, 8'd2, 1'b0);
    step();
    txn_valid = 1'b0; clear = 1'b1;
    #1 chk("e_req_hold0", req_valid, 1);
    step();
    clear = 1'b0;
    for (int i = 1; i < 3; i++) begin
      chk("e_req_hold", req_valid, 1);
      step();
    end
    req_ready = 1'b1;
    #1 chk("e_req_hs", req_valid, 1);
    step();
    chk("e_req_released", req_valid, 0);
    chk("e_discard_rsp_ready", rsp_ready, 1);
    feed(32'h600, 3, ok, trl);
    chk("e_discard_ok", ok, 1);
    chk("e_idle", busy, 0);
    chk("e_no_out", ov_cnt - o0, 0);
    chk("e_no_beats", got.size() - g0, 0);
    chk("e_no_txn_ready", tr_cnt - t0, 0);

    // Asynchronous reset mid-DATA, then a power-up-like transaction.
    out_ready = 1'b0;
    start_txn(35'h700, 8'd3, 1'b0);
    step(); step();
    feed(32'h700, 2, ok, trl);
    txn_valid = 1'b0;
    #2 rstnn = 1'b0;
    #1 chk("f_rst_outs", {req_valid, rsp_ready, out_valid, busy, done, txn_ready}, 0);
    chk("f_rst_req", {req_addr, req_alen, req_burden}, 0);
    chk("f_rst_out_data", {out_last, out_data}, 0);
    step();
    rstnn = 1'b1;
    step();
    run_vec(vtab[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dca_matrix_lsu_load.md
# dca_matrix_lsu_load

Load-side data mover of the DCA matrix LSU. It is the read counterpart of the LSU store path. It consumes the same transaction-info stream (bit address, burst length, last flag) and issues one LPIXM read request per transaction. It then collects the returned read beats in a small FIFO and presents them as a data stream, tagging the final beat of every burst. It sits between the matrix LSU transaction generator and the LPIXM memory port, feeding the matrix buffer write side.

## Interface
Parameters:
- BW_DATA, 32, LPIXM/AXI data width; power of two, at least 8.
- BW_ADDR, 32, byte address width.
- BW_ALEN, 8, burst length field width (AXI ALEN, beats minus 1).
- BW_LPI_BURDEN, 1, width of the LPIXM burden sideband.
- FIFO_DEPTH, 4, response FIFO entries; power of two, at least 2.
- Derived (not overridable): BW_BITADDR = BW_ADDR+3 and BW_OFS = log2(BW_DATA/8).

Ports:
- clk  in  1  block clock; single clock domain.
- rstnn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort (see Operation).
- enable  in  1  level; high while the active LSU instruction opcode is READ.
- burden  in  BW_LPI_BURDEN  sideband copied into every request.
- txn_valid  in  1  transaction info valid.
- txn_bitaddr  in  BW_BITADDR  start bit address.
- txn_alen  in  BW_ALEN  beats minus 1.
- txn_last  in  1  end-of-instruction marker; carries no transfer.
- txn_ready  out  1  transaction consumed.
- req_valid  out  1  LPIXM read request valid.
- req_ready  in  1  LPIXM request accepted.
- req_addr  out  BW_ADDR  byte address with the low BW_OFS bits forced to 0.
- req_alen  out  BW_ALEN  burst length.
- req_burden  out  BW_LPI_BURDEN  registered copy of burden.
- rsp_valid  in  1  read beat valid.
- rsp_ready  out  1  read beat accepted.
- rsp_data  in  BW_DATA  read beat data.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  BW_DATA  stream data.
- out_last  out  1  final beat of a burst.
- busy  out  1  high when the state is not IDLE or the FIFO is non-empty.
- done  out  1  one-cycle pulse on instruction completion.

## Operation
- State machine with states IDLE, REQ, DATA, FLUSH and DISCARD.
- IDLE, on enable & txn_valid & ~txn_last:
  - latch addr = (txn_bitaddr>>3) with the low BW_OFS bits cleared;
  - latch alen and burden;
  - go to REQ.
- IDLE, on enable & txn_valid & txn_last: go to FLUSH.
- txn_ready is never asserted in IDLE. The upstream holds the txn fields stable until txn_ready.
- REQ:
  - req_valid=1 with the latched fields;
  - on req_ready, load beat counter = alen and go to DATA.
- DATA:
  - rsp_ready = ~fifo_full; fullness is evaluated before any same-cycle pop;
  - each accepted beat pushes {data, last=(cnt==0)} and decrements cnt;
  - the accept with cnt==0 asserts txn_ready combinationally in that cycle and returns to IDLE.
- FLUSH:
  - wait for the FIFO to be empty;
  - in that cycle assert txn_ready and done together, then return to IDLE.
- FIFO: circular buffer with BW_DATA+1 bits per entry.
  - out_valid = ~empty; out_data/out_last are the head entry.
  - A pop occurs on out_valid & out_ready.
  - Simultaneous push and pop keeps occupancy unchanged, including when the FIFO is full (the pop is honored; the push is already blocked by rsp_ready).
- clear:
  - IDLE or FLUSH: go to IDLE.
  - REQ: keep req_valid until req_ready (no request retraction), then go to DISCARD with cnt=alen.
  - DATA: go to DISCARD.
  - The FIFO is emptied in all cases.
  - txn_ready and done are never asserted due to clear.
- DISCARD: rsp_ready=1; beats are counted and dropped; after the cnt==0 beat, go to IDLE.
- clear has priority over every other transition in the same cycle.
- enable low only blocks new txn acceptance. An in-flight transaction completes.

## Timing
- Reset values (rstnn low, asynchronous):
  - state IDLE, FIFO empty, cnt 0;
  - latched addr, alen and burden at 0;
  - all outputs 0, including req_addr, req_alen and req_burden.
- req_valid, req_addr, req_alen and req_burden are registered. req_valid first rises 1 cycle after txn acceptance in IDLE.
- rsp_ready, txn_ready and done are combinational from state, FIFO flags and inputs.
- Response-to-stream latency: a beat accepted at cycle t appears on out_valid at t+1.
- With out_ready held high and rsp_valid continuous, throughput is 1 beat per cycle.
- Minimum cycles per transaction: 1 (IDLE) + 1 (REQ, if req_ready is high) + alen+1 (DATA).

## Test plan
- bitaddr 0x10013, alen 0, BW_DATA 32, req_ready=1:
  - req_addr=0x2000 and req_alen=0 at cycle 1;
  - rsp 0xA5A5A5A5 produces out_data=0xA5A5A5A5 with out_last=1;
  - txn_ready pulses in the rsp accept cycle.
- alen 3, out_ready low:
  - 4 beats fill the FIFO (depth 4) and rsp_ready drops;
  - raising out_ready yields beats in order, with out_last only on the 4th.
- alen 5 with out_ready low: rsp_ready drops after 4 accepted beats, and no data is lost when out_ready rises.
- txn_last with 2 beats still in the FIFO: done and txn_ready stay low until the FIFO drains, then pulse for exactly 1 cycle together.
- clear mid-DATA after 1 of 4 beats:
  - the FIFO empties;
  - 3 remaining beats are accepted and dropped with no out_valid;
  - state returns to IDLE and txn_ready never asserts.
- clear asserted in REQ with req_ready low for 3 cycles: req_valid stays high until the handshake, then all alen+1 beats are discarded.
- rstnn asserted mid-DATA: all outputs go to 0 immediately, and the next txn behaves as after power-up.
